ws2812_rx: RTL and testbench

- Decodes a WS2812-style single-wire LED stream (pulse-width-coded bits, long-low reset) into 24-bit pixel words.
- Receive-side counterpart of our strip driver. Used for driver loopback self-test and for monitoring the tail of a daisy-chained strip.
- Emits one pulse per pixel, a frame-done summary, and error flags. Fully synchronous to clk; din is asynchronous.

---
 rtl/ws2812_rx_if.sv | 26 ++
 rtl/ws2812_rx.sv | 172 +++++++++++++++++
 tb/tb_ws2812_rx.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_rx_if.sv
// WS2812 receiver bus: serial line in, decoded pixel/frame/error strobes out.
// master = line driver / pixel consumer side, slave = the receiver.
interface ws2812_rx_if #(
   parameter int IDX_W = 9
);
   logic             din;
   logic [23:0]      pixel_data;
   logic [IDX_W-1:0] pixel_index;
   logic             pixel_valid;
   logic             frame_done;
   logic [IDX_W-1:0] frame_pixels;
   logic             bit_error;
   logic             busy;

   modport master (
      output din,
      input  pixel_data, pixel_index, pixel_valid,
      input  frame_done, frame_pixels, bit_error, busy
   );

   modport slave (
      input  din,
      output pixel_data, pixel_index, pixel_valid,
      output frame_done, frame_pixels, bit_error, busy
   );
endinterface

// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver. Measures high-pulse widths on a synchronized
// copy of din, decodes bits MSB-first into 24-bit pixels, and closes a frame
// after a long low. Any protocol violation flags bit_error and forces a re-arm
// (RESET_TIME of continuous low) before the next frame is accepted.
module ws2812_rx #(
   parameter int BIT_THRESHOLD = 35,
   parameter int MIN_HIGH      = 8,
   parameter int MAX_HIGH      = 62,
   parameter int RESET_TIME    = 2500,
   parameter int IDX_W         = 9
) (
   input  logic        clk,
   input  logic        rst,
   ws2812_rx_if.slave  rx
);

   localparam int LOW_W = $clog2(RESET_TIME + 1);
   localparam logic [6:0]       THR_C = 7'(BIT_THRESHOLD);
   localparam logic [6:0]       MIN_C = 7'(MIN_HIGH);
   localparam logic [6:0]       MAX_C = 7'(MAX_HIGH);
   localparam logic [LOW_W-1:0] RST_C = LOW_W'(RESET_TIME);

   typedef enum logic [1:0] {ARM, IDLE, HIGH, LOW} state_t;

   // two-flop synchronizer plus one history flop for edge detection
   logic [1:0]       sync_q;
   logic             ds_q;
   logic             ds, rise, fall;

   state_t           state_q;
   logic [6:0]       high_cnt_q;
   logic [LOW_W-1:0] low_cnt_q;
   logic [4:0]       bit_cnt_q;
   logic [IDX_W-1:0] pix_cnt_q;
   logic [23:0]      shift_q;

   logic [23:0]      pixel_data_q;
   logic [IDX_W-1:0] pixel_index_q;
   logic             pixel_valid_q;
   logic             frame_done_q;
   logic [IDX_W-1:0] frame_pixels_q;
   logic             bit_error_q;

   // saturating increments and the shift-in candidate
   logic [6:0]       high_inc;
   logic [LOW_W-1:0] low_inc;
   logic [IDX_W-1:0] pix_inc;
   logic [23:0]      shift_d;

   assign ds   = sync_q[1];
   assign rise = ds & ~ds_q;
   assign fall = ~ds & ds_q;

   assign high_inc = (high_cnt_q == '1) ? high_cnt_q : high_cnt_q + 7'd1;
   assign low_inc  = (low_cnt_q  == '1) ? low_cnt_q  : low_cnt_q + 1'b1;
   assign pix_inc  = (pix_cnt_q  == '1) ? pix_cnt_q  : pix_cnt_q + 1'b1;
   assign shift_d  = {shift_q[22:0], (high_cnt_q >= THR_C)};

   // bring the asynchronous line into the clk domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         ds_q   <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], rx.din};
         ds_q   <= ds;
      end
   end

   // receive FSM: width measurement, bit/pixel assembly, frame close, errors
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ARM;
         high_cnt_q     <= '0;
         low_cnt_q      <= '0;
         bit_cnt_q      <= '0;
         pix_cnt_q      <= '0;
         shift_q        <= '0;
         pixel_data_q   <= '0;
         pixel_index_q  <= '0;
         pixel_valid_q  <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_pixels_q <= '0;
         bit_error_q    <= 1'b0;
      end else begin
         pixel_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         bit_error_q   <= 1'b0;
         case (state_q)
            ARM: begin
               // wait for a clean long low; any high restarts the count
               if (ds) begin
                  low_cnt_q <= '0;
               end else if (low_inc >= RST_C) begin
                  low_cnt_q <= '0;
                  state_q   <= IDLE;
               end else begin
                  low_cnt_q <= low_inc;
               end
            end
            IDLE: begin
               if (rise) begin
                  high_cnt_q <= 7'd1;
                  bit_cnt_q  <= '0;
                  pix_cnt_q  <= '0;
                  state_q    <= HIGH;
               end
            end
            HIGH: begin
               if (fall) begin
                  if (high_cnt_q < MIN_C) begin
                     // glitch; this low sample already counts toward re-arm
                     bit_error_q <= 1'b1;
                     low_cnt_q   <= LOW_W'(1);
                     state_q     <= ARM;
                  end else begin
                     shift_q <= shift_d;
                     if (bit_cnt_q == 5'd23) begin
                        pixel_data_q  <= shift_d;
                        pixel_index_q <= pix_cnt_q;
                        pixel_valid_q <= 1'b1;
                        pix_cnt_q     <= pix_inc;
                        bit_cnt_q     <= '0;
                     end else begin
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                     end
                     low_cnt_q <= LOW_W'(1);
                     state_q   <= LOW;
                  end
               end else if (ds) begin
                  if (high_cnt_q >= MAX_C) begin
                     // stuck high: abandon the frame
                     bit_error_q <= 1'b1;
                     low_cnt_q   <= '0;
                     state_q     <= ARM;
                  end else begin
                     high_cnt_q <= high_inc;
                  end
               end
            end
            LOW: begin
               if (rise) begin
                  high_cnt_q <= 7'd1;
                  state_q    <= HIGH;
               end else if (!ds) begin
                  if (low_inc >= RST_C) begin
                     // frame end; a partial pixel is dropped and flagged
                     frame_done_q   <= 1'b1;
                     frame_pixels_q <= pix_cnt_q;
                     bit_error_q    <= (bit_cnt_q != 5'd0);
                     bit_cnt_q      <= '0;
                     low_cnt_q      <= '0;
                     state_q        <= IDLE;
                  end else begin
                     low_cnt_q <= low_inc;
                  end
               end
            end
            default: state_q <= ARM;
         endcase
      end
   end

   assign rx.pixel_data   = pixel_data_q;
   assign rx.pixel_index  = pixel_index_q;
   assign rx.pixel_valid  = pixel_valid_q;
   assign rx.frame_done   = frame_done_q;
   assign rx.frame_pixels = frame_pixels_q;
   assign rx.bit_error    = bit_error_q;
   assign rx.busy         = (state_q == HIGH) || (state_q == LOW);

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx. The line is driven as (level, length) segments; a
// pulse-level reference model turns each segment into expected strobes with
// their arrival cycle, and a monitor matches DUT strobes against those queues.
// Timing parameters are scaled down so the 160-pixel strip stays short.
module tb_ws2812_rx;
   localparam int THR  = 12;
   localparam int MINH = 4;
   localparam int MAXH = 20;
   localparam int RT   = 200;
   localparam int IW   = 9;
   localparam int IMAX = (1 << IW) - 1;
   localparam int LL   = RT + 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ws2812_rx_if #(.IDX_W(IW)) bus ();

   ws2812_rx #(
      .BIT_THRESHOLD(THR), .MIN_HIGH(MINH), .MAX_HIGH(MAXH),
      .RESET_TIME(RT), .IDX_W(IW)
   ) dut (
      .clk(clk), .rst(rst), .rx(bus)
   );

   typedef struct {
      int          cyc;
      logic [23:0] data;
      int          idx;
   } ev_t;

   ev_t qpix[$], qdone[$], qerr[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_fail = 0;

   // model: 0 = waiting for arm, 1 = armed idle, 2 = inside a frame
   int          m_st, m_low, m_bits, m_pix;
   logic [23:0] m_val;
   int          last_fp;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int sat(input int v);
      return (v > IMAX) ? IMAX : v;
   endfunction

   // drive one segment; must be called on a negedge
   task automatic seg(input logic lvl, input int n);
      int  s;
      ev_t e;
      s = cyc + 1;
      if (lvl) begin
         if (m_st == 0) begin
            m_low = 0;
         end else begin
            if (m_st == 1) begin
               m_bits = 0; m_pix = 0; m_st = 2;
            end
            if (n > MAXH) begin
               e.cyc = s + MAXH + 2; e.data = '0; e.idx = 0;
               qerr.push_back(e);
               m_st = 0; m_low = 0;
            end else if (n < MINH) begin
               e.cyc = s + n + 2; e.data = '0; e.idx = 0;
               qerr.push_back(e);
               m_st = 0; m_low = 0;
            end else begin
               m_val = {m_val[22:0], (n >= THR) ? 1'b1 : 1'b0};
               m_bits++;
               if (m_bits == 24) begin
                  e.cyc = s + n + 2; e.data = m_val; e.idx = sat(m_pix);
                  qpix.push_back(e);
                  m_pix++;
                  m_bits = 0;
               end
               m_low = 0;
            end
         end
      end else begin
         if (m_st == 0) begin
            if (m_low + n >= RT) begin m_st = 1; m_low = 0; end
            else m_low += n;
         end else if (m_st == 2) begin
            if (m_low + n >= RT) begin
               e.cyc = s + (RT - m_low) - 1 + 2; e.data = '0; e.idx = sat(m_pix);
               qdone.push_back(e);
               last_fp = sat(m_pix);
               if (m_bits != 0) qerr.push_back(e);
               m_st = 1; m_low = 0;
            end else begin
               m_low += n;
            end
         end
      end
      bus.din = lvl;
      repeat (n) @(negedge clk);
   endtask

   // top nb bits of d, MSB first, with random legal widths
   task automatic send_bits(input logic [23:0] d, input int nb, input bit fast);
      int hi, lo;
      for (int i = 0; i < nb; i++) begin
         if (d[23-i]) hi = fast ? $urandom_range(THR + 3, THR) : $urandom_range(MAXH, THR);
         else         hi = fast ? $urandom_range(MINH + 3, MINH) : $urandom_range(THR - 1, MINH);
         lo = fast ? $urandom_range(3, 1) : $urandom_range(10, 1);
         seg(1'b1, hi);
         seg(1'b0, lo);
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
      m_st = 0; m_low = 0; m_bits = 0; m_pix = 0; m_val = '0; last_fp = 0;
      chk("rst_data",  bus.pixel_data,   0);
      chk("rst_index", bus.pixel_index,  0);
      chk("rst_valid", bus.pixel_valid,  0);
      chk("rst_done",  bus.frame_done,   0);
      chk("rst_fpix",  bus.frame_pixels, 0);
      chk("rst_err",   bus.bit_error,    0);
      chk("rst_busy",  bus.busy,         0);
   endtask

   // close a frame and check the idle status and held pixel count
   task automatic end_frame(input string tag);
      seg(1'b0, LL);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_fpix"}, bus.frame_pixels, last_fp);
   endtask

   // match every strobe against the model's queues, including arrival cycle
   always @(negedge clk) begin : mon
      ev_t e;
      while (qpix.size() > 0 && qpix[0].cyc < cyc) begin
         e = qpix.pop_front(); chk("pix_missing", cyc, e.cyc);
      end
      while (qdone.size() > 0 && qdone[0].cyc < cyc) begin
         e = qdone.pop_front(); chk("done_missing", cyc, e.cyc);
      end
      while (qerr.size() > 0 && qerr[0].cyc < cyc) begin
         e = qerr.pop_front(); chk("err_missing", cyc, e.cyc);
      end
      if (bus.pixel_valid) begin
         if (qpix.size() == 0) chk("pix_extra", 1, 0);
         else begin
            e = qpix.pop_front();
            chk("pix_cyc",  cyc, e.cyc);
            chk("pix_data", bus.pixel_data, e.data);
            chk("pix_idx",  bus.pixel_index, e.idx);
         end
      end
      if (bus.frame_done) begin
         if (qdone.size() == 0) chk("done_extra", 1, 0);
         else begin
            e = qdone.pop_front();
            chk("done_cyc",  cyc, e.cyc);
            chk("done_fpix", bus.frame_pixels, e.idx);
         end
      end
      if (bus.bit_error) begin
         if (qerr.size() == 0) chk("err_extra", 1, 0);
         else begin
            e = qerr.pop_front();
            chk("err_cyc", cyc, e.cyc);
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog expired at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] r;
      bus.din = 1'b0;
      m_val = '0;
      do_reset(3);
      seg(1'b0, LL);

      // single pixel, with a busy check mid-frame
      send_bits(24'hA50FF0, 12, 1'b0);
      seg(1'b0, 5);
      chk("mid_busy", bus.busy, 1);
      send_bits(24'h00FF0 << 12, 12, 1'b0);
      end_frame("single");
      chk("single_data", bus.pixel_data, 24'hA50FF0);
      chk("single_fp", bus.frame_pixels, 1);

      // full strip
      for (int i = 0; i < 160; i++) begin
         r = {i[7:0], ~i[7:0], 8'h5A};
         send_bits(r, 24, 1'b1);
      end
      end_frame("strip");
      chk("strip_fp", bus.frame_pixels, 160);
      chk("strip_idx", bus.pixel_index, 159);

      // threshold boundaries, then a glitch that aborts the frame
      seg(1'b1, THR - 1); seg(1'b0, 5);
      seg(1'b1, THR);     seg(1'b0, 5);
      seg(1'b1, MINH);    seg(1'b0, 5);
      seg(1'b1, MAXH);    seg(1'b0, 5);
      r = 24'($urandom());
      send_bits(r << 4, 20, 1'b0);
      seg(1'b1, MINH - 1); seg(1'b0, 5);
      send_bits(24'($urandom()), 5, 1'b0);
      seg(1'b0, LL);
      chk("thr_bits", bus.pixel_data[23:20], 4'b0101);
      chk("thr_busy", bus.busy, 0);

      // stuck high mid-frame
      send_bits(24'($urandom()), 5, 1'b0);
      seg(1'b1, 100);
      seg(1'b0, LL);
      chk("stuck_busy", bus.busy, 0);

      // one good pixel plus a partial one
      send_bits(24'($urandom()), 24, 1'b0);
      send_bits(24'($urandom()), 12, 1'b0);
      end_frame("partial");
      chk("partial_fp", bus.frame_pixels, 1);

      // reset mid-pixel; immediate bits must be ignored
      send_bits(24'($urandom()), 10, 1'b0);
      do_reset(1);
      send_bits(24'($urandom()), 8, 1'b0);
      seg(1'b0, LL);
      send_bits(24'h123456, 24, 1'b0);
      end_frame("after_rst");
      chk("after_rst_data", bus.pixel_data, 24'h123456);
      chk("after_rst_idx", bus.pixel_index, 0);

      // random frames, some ending in a partial pixel
      for (int f = 0; f < 4; f++) begin
         int np;
         np = $urandom_range(3, 1);
         for (int p = 0; p < np; p++) send_bits(24'($urandom()), 24, 1'b0);
         if ($urandom_range(1, 0) == 1) send_bits(24'($urandom()), $urandom_range(23, 1), 1'b0);
         end_frame("rand");
      end

      repeat (5) @(negedge clk);
      chk("pix_left",  qpix.size(),  0);
      chk("done_left", qdone.size(), 0);
      chk("err_left",  qerr.size(),  0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
